// File: rtl/sfx_tone_writer.sv
// sfx_tone_writer
//
// Generates square-wave sound effects (a falling-pitch "jump" sweep and a
// fixed-pitch "walk" buzz) and streams 24-bit samples into the audio codec's
// DAC write FIFO. It runs continuously: while no effect is playing it keeps
// writing zero samples, so the DAC never starves.
//
// Ports:
//   clk_50      - 50 MHz system clock
//   reset       - asynchronous reset, active high
//   jump        - jump request level from the microphone analyser
//   walk        - walk request level from the microphone analyser
//   write_ready - codec DAC FIFO has room for a sample
//   write       - one-cycle write strobe to the codec (at most every 2nd cycle)
//   left_out    - left sample, valid while write is high, held between strobes
//   right_out   - right sample, always identical to left_out
//   busy        - high while an effect is playing
//   effect      - current effect: 00 idle, 01 walk, 10 jump
module sfx_tone_writer #(
  parameter logic [23:0] AMPLITUDE       = 24'h1FFFFF,
  parameter int          JUMP_HALF_START = 60,
  parameter int          JUMP_HALF_END   = 20,
  parameter int          JUMP_STEP       = 240,
  parameter int          JUMP_LEN        = 9600,
  parameter int          WALK_HALF       = 120,
  parameter int          WALK_LEN        = 2400
) (
  input  logic        clk_50,
  input  logic        reset,
  input  logic        jump,
  input  logic        walk,
  input  logic        write_ready,
  output logic        write,
  output logic [23:0] left_out,
  output logic [23:0] right_out,
  output logic        busy,
  output logic [1:0]  effect
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WALK = 2'b01,
    JUMP = 2'b10
  } state_t;

  localparam logic [23:0] AMP_POS        = AMPLITUDE;
  localparam logic [23:0] AMP_NEG        = ~AMPLITUDE + 24'd1;
  localparam logic [7:0]  JUMP_START_W   = 8'(JUMP_HALF_START);
  localparam logic [7:0]  JUMP_END_W     = 8'(JUMP_HALF_END);
  localparam logic [7:0]  WALK_HALF_W    = 8'(WALK_HALF);
  localparam logic [15:0] JUMP_STEP_LAST = 16'(JUMP_STEP - 1);
  localparam logic [15:0] JUMP_LEN_LAST  = 16'(JUMP_LEN - 1);
  localparam logic [15:0] WALK_LEN_LAST  = 16'(WALK_LEN - 1);

  state_t      state;
  logic        jump_q;
  logic        walk_q;
  logic        phase;
  logic [15:0] phase_cnt;
  logic [15:0] sample_cnt;
  logic [15:0] step_cnt;
  logic [7:0]  half;

  logic        jump_start;
  logic        walk_start;
  logic        write_next;
  logic        commit;
  logic        last_commit;
  logic        phase_wrap;
  logic [15:0] len_last;
  logic [23:0] load_data;

  // Trigger decoding, handshake and the sample that goes out on the next
  // strobe. A jump edge always wins; a walk edge is dropped while a jump
  // plays. When an effect starts in the same cycle a strobe is loaded, the
  // strobe already carries the new effect's first (positive) sample so the
  // effect's sample count and the data stream stay aligned.
  always_comb begin
    jump_start  = jump & ~jump_q;
    walk_start  = walk & ~walk_q & ~jump_start & (state != JUMP);
    write_next  = write_ready & ~write;
    commit      = write;
    len_last    = (state == JUMP) ? JUMP_LEN_LAST : WALK_LEN_LAST;
    last_commit = commit & (state != IDLE) & (sample_cnt == len_last);
    // Comparing with >= lets a count that overshot a freshly shortened
    // half-period wrap on the very next commit.
    phase_wrap  = (phase_cnt >= ({8'd0, half} - 16'd1));
    load_data   = 24'd0;
    if (jump_start || walk_start) begin
      load_data = AMP_POS;
    end else if (state != IDLE) begin
      load_data = phase ? AMP_NEG : AMP_POS;
    end
  end

  // Single registered FSM: trigger history, write strobe and sample
  // registers, effect state with its tone counters, and the status outputs.
  // Counters only move on committed samples (cycles where write is high).
  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      jump_q     <= 1'b0;
      walk_q     <= 1'b0;
      write      <= 1'b0;
      left_out   <= 24'd0;
      right_out  <= 24'd0;
      busy       <= 1'b0;
      effect     <= 2'b00;
      phase      <= 1'b0;
      phase_cnt  <= 16'd0;
      sample_cnt <= 16'd0;
      step_cnt   <= 16'd0;
      half       <= 8'd0;
    end else begin
      jump_q <= jump;
      walk_q <= walk;
      write  <= write_next;
      if (write_next) begin
        left_out  <= load_data;
        right_out <= load_data;
      end

      if (jump_start) begin
        state      <= JUMP;
        busy       <= 1'b1;
        effect     <= 2'b10;
        phase      <= 1'b0;
        phase_cnt  <= 16'd0;
        sample_cnt <= 16'd0;
        step_cnt   <= 16'd0;
        half       <= JUMP_START_W;
      end else if (walk_start) begin
        state      <= WALK;
        busy       <= 1'b1;
        effect     <= 2'b01;
        phase      <= 1'b0;
        phase_cnt  <= 16'd0;
        sample_cnt <= 16'd0;
        step_cnt   <= 16'd0;
        half       <= WALK_HALF_W;
      end else if (commit && (state != IDLE)) begin
        if (last_commit) begin
          state      <= IDLE;
          busy       <= 1'b0;
          effect     <= 2'b00;
          phase      <= 1'b0;
          phase_cnt  <= 16'd0;
          sample_cnt <= 16'd0;
          step_cnt   <= 16'd0;
          half       <= 8'd0;
        end else begin
          sample_cnt <= sample_cnt + 16'd1;
          if (phase_wrap) begin
            phase_cnt <= 16'd0;
            phase     <= ~phase;
          end else begin
            phase_cnt <= phase_cnt + 16'd1;
          end
          // Pitch sweep: shorten the half-period every JUMP_STEP commits
          // until it reaches the floor.
          if (state == JUMP) begin
            if (step_cnt == JUMP_STEP_LAST) begin
              step_cnt <= 16'd0;
              if (half > JUMP_END_W) begin
                half <= half - 8'd1;
              end
            end else begin
              step_cnt <= step_cnt + 16'd1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_sfx_tone_writer.sv
// tb_sfx_tone_writer
//
// Directed bench for sfx_tone_writer built with short tones
// (WALK_HALF=4, WALK_LEN=16, JUMP 6->2 every 8 samples, JUMP_LEN=64) so
// whole effects can be compared against hand-written sample tables.
module tb_sfx_tone_writer;

  localparam logic [23:0] POS = 24'h1FFFFF;
  localparam logic [23:0] NEG = 24'hE00001;

  logic        clk_50 = 1'b0;
  logic        reset  = 1'b1;
  logic        jump   = 1'b0;
  logic        walk   = 1'b0;
  logic        write_ready = 1'b1;
  logic        write;
  logic [23:0] left_out;
  logic [23:0] right_out;
  logic        busy;
  logic [1:0]  effect;

  int total = 0;
  int bad   = 0;

  // Half-period runs of the swept jump tone, alternating +/- starting with +.
  int          jump_runs [24] = '{6, 5, 5, 4, 4, 3, 3, 3,
                                  2, 2, 2, 2, 2, 2, 2, 2, 2, 2, 2, 2, 2, 2, 2,
                                  1};
  logic [23:0] jump_exp [64];

  sfx_tone_writer #(
    .AMPLITUDE       (24'h1FFFFF),
    .JUMP_HALF_START (6),
    .JUMP_HALF_END   (2),
    .JUMP_STEP       (8),
    .JUMP_LEN        (64),
    .WALK_HALF       (4),
    .WALK_LEN        (16)
  ) dut (
    .clk_50      (clk_50),
    .reset       (reset),
    .jump        (jump),
    .walk        (walk),
    .write_ready (write_ready),
    .write       (write),
    .left_out    (left_out),
    .right_out   (right_out),
    .busy        (busy),
    .effect      (effect)
  );

  always #5 clk_50 = ~clk_50;

  // Walk tone: four positive samples, four negative, repeated.
  function automatic logic [23:0] walk_exp(input int n);
    return (((n / 4) % 2) == 0) ? POS : NEG;
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for the next negedge on which write is high.
  task automatic wait_commit(input string tag, output logic [23:0] d);
    logic got;
    got = 1'b0;
    d   = 24'd0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk_50);
      if (write === 1'b1) begin
        got = 1'b1;
        d   = left_out;
      end
    end
    check_output({tag, "_timeout"}, 32'(got), 32'd1);
  endtask

  task automatic expect_jump(input int first, input int count, input string tag);
    logic [23:0] d;
    for (int i = 0; i < count; i++) begin
      wait_commit(tag, d);
      check_output($sformatf("%s[%0d]", tag, first + i), 32'(d),
                   32'(jump_exp[first + i]));
    end
  endtask

  task automatic expect_walk(input int first, input int count, input string tag);
    logic [23:0] d;
    for (int i = 0; i < count; i++) begin
      wait_commit(tag, d);
      check_output($sformatf("%s[%0d]", tag, first + i), 32'(d),
                   32'(walk_exp(first + i)));
    end
  endtask

  // After an effect finishes the stream must return to zero samples.
  task automatic expect_idle_commit(input string tag);
    logic [23:0] d;
    wait_commit(tag, d);
    check_output({tag, "_data"}, 32'(d), 32'd0);
    check_output({tag, "_busy"}, 32'(busy), 32'd0);
    check_output({tag, "_effect"}, 32'(effect), 32'd0);
  endtask

  initial begin
    int          idx;
    int          n;
    logic        have_last;
    logic [23:0] last;
    logic [23:0] d;

    idx = 0;
    for (int r = 0; r < 24; r++) begin
      for (int j = 0; j < jump_runs[r]; j++) begin
        jump_exp[idx] = ((r % 2) == 0) ? POS : NEG;
        idx++;
      end
    end

    // 1. Reset values and the idle zero stream.
    @(negedge clk_50);
    check_output("rst_write", 32'(write), 32'd0);
    check_output("rst_left", 32'(left_out), 32'd0);
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_effect", 32'(effect), 32'd0);
    @(negedge clk_50);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_50);
      check_output($sformatf("idle_write[%0d]", i), 32'(write),
                   ((i % 2) == 0) ? 32'd1 : 32'd0);
      check_output($sformatf("idle_left[%0d]", i), 32'(left_out), 32'd0);
      check_output($sformatf("idle_busy[%0d]", i), 32'(busy), 32'd0);
      check_output($sformatf("idle_effect[%0d]", i), 32'(effect), 32'd0);
    end

    // 2. Walk tone, 16 samples.
    $display("[TB] walk tone");
    walk = 1'b1;
    expect_walk(0, 1, "walk");
    walk = 1'b0;
    check_output("walk_busy", 32'(busy), 32'd1);
    check_output("walk_effect", 32'(effect), 32'd1);
    check_output("walk_right", 32'(right_out), 32'(left_out));
    expect_walk(1, 15, "walk");
    expect_idle_commit("walk_end");

    // 3. Jump sweep, 64 samples.
    $display("[TB] jump sweep");
    jump = 1'b1;
    expect_jump(0, 1, "jump");
    jump = 1'b0;
    check_output("jump_effect", 32'(effect), 32'd2);
    expect_jump(1, 63, "jump");
    expect_idle_commit("jump_end");

    // 4. Priority, ignored walk, and jump retrigger after the sweep advanced.
    $display("[TB] priority and retrigger");
    jump = 1'b1;
    walk = 1'b1;
    @(negedge clk_50);
    check_output("prio_effect", 32'(effect), 32'd2);
    check_output("prio_busy", 32'(busy), 32'd1);
    jump = 1'b0;
    walk = 1'b0;
    @(negedge clk_50);
    jump = 1'b1;
    expect_jump(0, 1, "rejump");
    jump = 1'b0;
    expect_jump(1, 19, "rejump");
    walk = 1'b1;
    expect_jump(20, 10, "walk_ignored");
    check_output("walk_ignored_effect", 32'(effect), 32'd2);
    walk = 1'b0;
    jump = 1'b1;
    expect_jump(0, 1, "restart");
    jump = 1'b0;
    expect_jump(1, 63, "restart");
    expect_idle_commit("restart_end");

    // 5. Walk under random backpressure.
    $display("[TB] backpressure");
    walk      = 1'b1;
    n         = 0;
    have_last = 1'b0;
    last      = 24'd0;
    for (int c = 0; c < 600 && n < 16; c++) begin
      @(negedge clk_50);
      check_output("bp_right", 32'(right_out), 32'(left_out));
      if (write === 1'b1) begin
        check_output("bp_ready", 32'(write_ready), 32'd1);
        check_output($sformatf("bp_data[%0d]", n), 32'(left_out), 32'(walk_exp(n)));
        last      = left_out;
        have_last = 1'b1;
        n++;
        walk = 1'b0;
      end else if (have_last) begin
        check_output("bp_stable", 32'(left_out), 32'(last));
      end
      write_ready = 1'($urandom_range(0, 1));
    end
    check_output("bp_count", 32'(n), 32'd16);
    walk        = 1'b0;
    write_ready = 1'b1;
    expect_idle_commit("bp_end");

    // 6. Reset in the middle of a walk.
    $display("[TB] reset mid-effect");
    walk = 1'b1;
    expect_walk(0, 1, "prerst");
    walk = 1'b0;
    expect_walk(1, 6, "prerst");
    wait_commit("rst7", d);
    #1 reset = 1'b1;
    #1;
    check_output("midrst_write", 32'(write), 32'd0);
    check_output("midrst_busy", 32'(busy), 32'd0);
    check_output("midrst_left", 32'(left_out), 32'd0);
    check_output("midrst_right", 32'(right_out), 32'd0);
    check_output("midrst_effect", 32'(effect), 32'd0);
    @(negedge clk_50);
    @(negedge clk_50);
    reset = 1'b0;
    walk  = 1'b1;
    expect_walk(0, 1, "postrst");
    walk = 1'b0;
    check_output("postrst_effect", 32'(effect), 32'd1);
    expect_walk(1, 4, "postrst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sfx_tone_writer.md
Name: sfx_tone_writer

Overview:
- Playback-side counterpart to the microphone analyser: generates square-wave sound effects and writes 24-bit samples into the audio codec's DAC write FIFO.
- Triggered by the `jump` and `walk` levels the analyser produces.
- Handshakes with the codec through `write_ready` and `write`, the mirror of the analyser's `read_ready` and `read`.
- Sits between the game/analyser logic and the audio codec core.

Parameters:
- AMPLITUDE, 24'h1FFFFF: positive peak of the square wave; the negative half is the two's complement of this value.
- JUMP_HALF_START, 60: initial half-period of the jump tone, in samples.
- JUMP_HALF_END, 20: minimum half-period of the jump tone; the sweep stops here.
- JUMP_STEP, 240: number of committed samples between 1-sample decrements of the jump half-period.
- JUMP_LEN, 9600: length of the jump effect in committed samples.
- WALK_HALF, 120: fixed half-period of the walk tone, in samples.
- WALK_LEN, 2400: length of the walk effect in committed samples.

Ports:
- clk_50  input  1  system clock, 50 MHz.
- reset  input  1  asynchronous reset, active-high.
- jump  input  1  jump request level from the analyser.
- walk  input  1  walk request level from the analyser.
- write_ready  input  1  codec DAC FIFO has space.
- write  output  1  one-cycle write strobe to the codec.
- left_out  output  24  left-channel sample, valid while `write` is high.
- right_out  output  24  right-channel sample, always equal to `left_out`.
- busy  output  1  high while an effect is playing.
- effect  output  2  current effect: 00 idle, 01 walk, 10 jump.

Behaviour:
- Clock and reset: single clock, clk_50. Reset is asynchronous and active-high.
- Reset values: state IDLE; `write`=0; `left_out`=`right_out`=0; `busy`=0; `effect`=00; all counters, phase and edge registers 0.
- Trigger detection: `jump` and `walk` are registered once. A start event is a rising edge: current sample 1, previous registered value 0. Levels that stay high do not retrigger.
- Write handshake: `write` is registered and equals `write_ready & ~write`, so at most one strobe every two cycles.
  - `left_out` and `right_out` are registered in the same cycle `write` rises and stay stable until the next strobe.
  - A sample is committed in each cycle where `write`=1.
  - Writes continue in IDLE with data 0, so the DAC stream never starves.
- State machine: IDLE, WALK, JUMP.
  - IDLE to JUMP on a jump edge. IDLE to WALK on a walk edge.
  - Simultaneous jump and walk edges: JUMP wins.
  - Jump edge in WALK or JUMP: restart JUMP with counters reset.
  - Walk edge in WALK: restart WALK. Walk edge in JUMP: ignored.
  - End of effect: on the commit of sample LEN-1 (sample count == LEN-1 while `write`=1), return to IDLE.
- Tone generation: counters advance only on committed samples.
  - On entry to an effect: phase=0, phase count=0, sample count=0, half-period=JUMP_HALF_START or WALK_HALF, step count=0.
  - Committed data is +AMPLITUDE when phase=0 and -AMPLITUDE when phase=1.
  - After each commit, phase count increments. When it reaches half-1, it wraps to 0 and phase toggles.
- Jump sweep: after each commit, step count increments. When it reaches JUMP_STEP-1, it wraps to 0 and half decrements by 1, saturating at JUMP_HALF_END.
  - If half decrements while phase count already ≥ the new half-1, the wrap happens on the next commit; no out-of-range count persists.
- Width rules: sample, step and phase counters are 16 bits. Half-period is 8 bits. Data is two's complement 24 bits.
- Status outputs: `busy` = (state != IDLE). `effect` encodes the state, updating the cycle after the transition.
- Edge case: a trigger arriving in the same cycle as a commit restarts the counters. The committed data in that cycle still belongs to the old state.
- Reset mid-effect: immediate return to IDLE, and any in-flight `write` is dropped.

Test Plan:
1. Reset and idle stream: hold `reset`, release, tie `write_ready`=1. Expect `write` to toggle 0,1,0,1 with `left_out`=0, and `busy`=0, `effect`=00.
2. Walk tone (WALK_HALF=4, WALK_LEN=16): pulse `walk` with `write_ready`=1. Expect 16 committed samples in the pattern 4×0x1FFFFF, 4×0xE00001 repeated, then `busy`=0 and zero data.
3. Jump sweep (JUMP_HALF_START=6, JUMP_HALF_END=2, JUMP_STEP=8, JUMP_LEN=64): pulse `jump`. Expect half-period runs of 6, then 5 after 8 commits, down to 2 and holding there. Exactly 64 non-zero samples.
4. Priority and retrigger:
   - Raise `jump` and `walk` in the same cycle: expect `effect`=10.
   - Raise `walk` mid-jump: ignored.
   - Re-raise `jump` mid-jump: sample count restarts and the half-period returns to JUMP_HALF_START.
5. Backpressure: toggle `write_ready` randomly during walk. Expect no `write` while `write_ready`=0, an unchanged committed-sample sequence versus scenario 2, and data stable between strobes.
6. Reset mid-effect: assert `reset` at commit 7 of a walk. Expect `write`, `busy` and `left_out` at 0 immediately. After release, a new walk starts again from +AMPLITUDE.
